instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the five-stage RISC-V core: holds the program counter, owns the instruction memory, and produces the PC, PC+4 and instruction words latched by the IF/ID pipeline register. It also implements the program-load path from the debug unit: a byte stream is assembled into little-endian words and written to instruction memory. A run/halt state machine gates fetching. Branch/jump redirects and hazard stalls come from downstream stages.

## Interface
- `NB_INSTR`, 32, instruction width
- `NB_PC`, 32, program counter width
- `IMEM_AW`, 10, instruction memory word-address width (1024 words)
- `clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_en`  in  1  pipeline advance (debug unit run/step)
- `i_stall`  in  1  load-use stall from hazard unit; hold PC
- `i_redirect`  in  1  taken branch/jump from EX
- `i_redirect_pc`  in  NB_PC  redirect target
- `i_load_start`  in  1  begin program load
- `i_load_valid`  in  1  `i_load_byte` valid this cycle
- `i_load_byte`  in  8  program byte, little-endian order
- `i_load_done`  in  1  end program load
- `i_run`  in  1  start execution from PC 0
- `o_pc`  out  NB_PC  current fetch PC (to IF/ID `i_pc`)
- `o_pc_next`  out  NB_PC  `o_pc`+4 (to IF/ID `i_pc_next`)
- `o_instr`  out  NB_INSTR  fetched instruction or NOP (to IF/ID `i_instr`)
- `o_state`  out  2  FSM state (debug readback)
- `o_halt`  out  1  high in HALTED
- `o_load_words`  out  IMEM_AW+1  words written in last/current load

## Operation
- States: IDLE=0, LOAD=1, RUN=2, HALTED=3.
- IDLE/HALTED:
  - `i_load_start` → LOAD; byte counter and `o_load_words` cleared.
  - else `i_run` → RUN; PC set to 0.
  - `i_load_start` beats `i_run` when both are high.
- LOAD:
  - Each `i_load_valid` shifts `i_load_byte` into the word assembler; byte 0 lands in bits [7:0].
  - On the 4th byte, the word is written to `imem[o_load_words]`, `o_load_words`++, byte counter back to 0.
  - `i_load_done` → IDLE; a partial word is discarded.
  - A `i_load_valid` in the same cycle as `i_load_done` is processed first.
  - Once `o_load_words` reaches 2^IMEM_AW, further writes are dropped.
- RUN, fetched word = `imem[o_pc[IMEM_AW+1:2]]` (combinational read; PC bits [1:0] and bits above IMEM_AW+1 ignored, so addresses wrap). When `i_en`=1:
  - `i_redirect`=1 → PC ← `i_redirect_pc`. Redirect has priority over stall and halt.
  - else `i_stall`=1 → PC holds.
  - else fetched word == HALT_INSTR (32'hFFFF_FFFF) → PC holds, → HALTED.
  - else PC ← PC+4.
- `i_en`=0 → PC and state hold.
- `o_instr` = NOP (32'h0000_0013) when state≠RUN, or when the fetched word is HALT_INSTR; otherwise the fetched word.
- `o_pc_next` = `o_pc`+4 modulo 2^NB_PC, combinational.
- `i_load_start`, `i_load_valid`, `i_load_done` and `i_run` are ignored in RUN. Memory is not writable while running.

## Timing
- Reset values: `o_pc`=0, `o_pc_next`=4, `o_instr`=NOP, `o_state`=IDLE, `o_halt`=0, `o_load_words`=0. Byte counter is cleared. Memory contents are not reset.
- Reset mid-load: the partial word is lost and already-written words stay in memory. Reset mid-run returns to IDLE.
- PC update is registered. A redirect asserted in cycle n gives `o_pc`=`i_redirect_pc` in cycle n+1, and `o_instr` reads the target in that same cycle.
- Memory write occurs at the edge ending the cycle of the 4th byte. The word is readable the next cycle.
- HALTED is entered at the edge after HALT_INSTR is presented with `i_en`=1 and no redirect/stall. `o_halt` rises in the following cycle.
- Throughput: one instruction per cycle when `i_en`=1 and stall=0.

## Structure
- Shared package `cpu_pkg`: NOP_INSTR, HALT_INSTR, fetch state encodings, PC_STEP=4.
- Sub-module `instr_mem`: word-wide, synchronous write, asynchronous read, depth 2^IMEM_AW. Loader FSM, word assembler and PC logic stay in `instr_fetch_unit`.

## Test plan
- Load bytes 13,05,10,00 then FF,FF,FF,FF, done, run with `i_en`=1 → `o_load_words`=2; cycle 1 `o_pc`=0 with `o_instr`=32'h0010_0513; next `o_pc`=4 with `o_instr`=NOP; then `o_halt`=1 and PC stays at 4.
- Run a 4-word program with `i_stall` high for 2 cycles at PC=8 → `o_pc` holds 8 for 2 cycles, then 12. `o_pc_next`=`o_pc`+4 throughout.
- `i_redirect`=1 with `i_redirect_pc`=0x20 and `i_stall`=1, same cycle → next `o_pc`=0x20.
- Redirect asserted while the fetched word is HALT_INSTR → no halt; PC takes the target.
- Load 6 bytes then done → `o_load_words`=1; bytes 5–6 discarded; imem[1] unchanged.
- `i_rst` after 2 bytes of a load → state IDLE, byte counter 0; a new load's first byte lands in bits [7:0].

Source files
------------

// File: rtl/cpu_pkg.sv
// Constants and encodings shared by the fetch stage and its neighbours.
// Covers instruction encodings, fetch FSM state codes and the PC step.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Word-wide instruction memory with a synchronous write port and an asynchronous read port.
// Contents are deliberately not reset, so a program survives a core reset.
module instr_mem #(
  parameter int NB_DATA = 32,
  parameter int AW      = 10
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, run/halt sequencing and the byte-stream program loader.
//   state   | meaning
//   IDLE    | waiting for a program load or a run command
//   LOAD    | assembling little-endian bytes into words and writing imem
//   RUN     | fetching one instruction per enabled cycle
//   HALTED  | HALT_INSTR reached; PC frozen until load or run
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int NB_INSTR = 32,
  parameter int NB_PC    = 32,
  parameter int IMEM_AW  = 10
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [NB_PC-1:0]    i_redirect_pc,
  input  logic                i_load_start,
  input  logic                i_load_valid,
  input  logic [7:0]          i_load_byte,
  input  logic                i_load_done,
  input  logic                i_run,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [1:0]          o_state,
  output logic                o_halt,
  output logic [IMEM_AW:0]    o_load_words
);

  fetch_state_t        state_q, state_d;
  logic [NB_PC-1:0]    pc_q, pc_d;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         word_q;
  logic [IMEM_AW:0]    load_words_q;
  logic [NB_INSTR-1:0] fetched;
  logic                is_halt;
  logic                load_clr;
  logic                load_accept;
  logic                mem_we;
  logic                imem_full;

  instr_mem #(
    .NB_DATA (NB_INSTR),
    .AW      (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .i_we    (mem_we),
    .i_waddr (load_words_q[IMEM_AW-1:0]),
    .i_wdata ({i_load_byte, word_q}),
    .i_raddr (pc_q[IMEM_AW+1:2]),
    .o_rdata (fetched)
  );

  assign is_halt     = (fetched == NB_INSTR'(HALT_INSTR));
  // Saturating counter: the top bit is only ever set once every word has been written.
  assign imem_full   = load_words_q[IMEM_AW];
  assign load_accept = (state_q == ST_LOAD) && i_load_valid;
  assign mem_we      = load_accept && (byte_cnt_q == 2'd3) && !imem_full;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (i_load_start) begin
          state_d  = ST_LOAD;
          load_clr = 1'b1;
        end else if (i_run) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_LOAD: begin
        if (i_load_done) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_en) begin
          if (i_redirect)   pc_d = i_redirect_pc;
          else if (i_stall) pc_d = pc_q;
          else if (is_halt) state_d = ST_HALTED;
          else              pc_d = pc_q + NB_PC'(PC_STEP);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      byte_cnt_q   <= '0;
      word_q       <= '0;
      load_words_q <= '0;
    end else if (load_clr) begin
      byte_cnt_q   <= '0;
      load_words_q <= '0;
    end else begin
      if (load_accept) begin
        word_q     <= {i_load_byte, word_q[23:8]};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (mem_we) load_words_q <= load_words_q + {{IMEM_AW{1'b0}}, 1'b1};
      end
      // A byte arriving with done is consumed above; any leftover partial word is dropped.
      if ((state_q == ST_LOAD) && i_load_done) byte_cnt_q <= '0;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_next    = pc_q + NB_PC'(PC_STEP);
  assign o_instr      = ((state_q == ST_RUN) && !is_halt) ? fetched : NB_INSTR'(NOP_INSTR);
  assign o_state      = state_q;
  assign o_halt       = (state_q == ST_HALTED);
  assign o_load_words = load_words_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program load, run, stall, redirect, halt and reset cases.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_load_start = 1'b0;
  logic        i_load_valid = 1'b0;
  logic [7:0]  i_load_byte = '0;
  logic        i_load_done = 1'b0;
  logic        i_run = 1'b0;
  logic [31:0] o_pc, o_pc_next, o_instr;
  logic [1:0]  o_state;
  logic        o_halt;
  logic [10:0] o_load_words;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_load_start  (i_load_start),
    .i_load_valid  (i_load_valid),
    .i_load_byte   (i_load_byte),
    .i_load_done   (i_load_done),
    .i_run         (i_run),
    .o_pc          (o_pc),
    .o_pc_next     (o_pc_next),
    .o_instr       (o_instr),
    .o_state       (o_state),
    .o_halt        (o_halt),
    .o_load_words  (o_load_words)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, sim time %0t required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    step();
    i_load_valid = 1'b0;
  endtask

  task automatic start_load();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
  endtask

  task automatic finish_load();
    i_load_done = 1'b1;
    step();
    i_load_done = 1'b0;
  endtask

  task automatic start_run();
    i_run = 1'b1;
    step();
    i_run = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want %h", o_pc, 32'd0); end
    checks++; if (o_pc_next !== 32'd4) begin errors++; $display("FAIL rst_pc_next: got %h want %h", o_pc_next, 32'd4); end
    checks++; if (o_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", o_instr, NOP); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", o_state); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b want 0", o_halt); end
    checks++; if (o_load_words !== 11'd0) begin errors++; $display("FAIL rst_load_words: got %0d want 0", o_load_words); end
    i_rst = 1'b0;
  endtask

  task automatic test_load_and_halt();
    logic [7:0] prog [0:7];
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_load();
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL load_state: got %0d want 1", o_state); end
    checks++; if (o_instr !== NOP) begin errors++; $display("FAIL load_instr_nop: got %h want %h", o_instr, NOP); end
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    finish_load();
    checks++; if (o_load_words !== 11'd2) begin errors++; $display("FAIL load_words2: got %0d want 2", o_load_words); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL load_done_idle: got %0d want 0", o_state); end
    i_en = 1'b1;
    start_run();
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL run_pc0: got %h want 0", o_pc); end
    checks++; if (o_instr !== 32'h0010_0513) begin errors++; $display("FAIL run_instr0: got %h want 00100513", o_instr); end
    checks++; if (o_pc_next !== 32'd4) begin errors++; $display("FAIL run_pc_next0: got %h want 4", o_pc_next); end
    step();
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL run_pc4: got %h want 4", o_pc); end
    checks++; if (o_instr !== NOP) begin errors++; $display("FAIL halt_word_nop: got %h want %h", o_instr, NOP); end
    checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", o_halt); end
    step();
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", o_halt); end
    checks++; if (o_state !== 2'd3) begin errors++; $display("FAIL halt_state: got %0d want 3", o_state); end
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL halt_pc: got %h want 4", o_pc); end
    step();
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL halt_pc_hold: got %h want 4", o_pc); end
  endtask

  task automatic test_stall();
    logic [7:0] prog [0:15];
    logic [31:0] exp_pc [0:3];
    logic        stall_seq [0:3];
    prog = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00,
             8'h93, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_pc    = '{32'd8, 32'd8, 32'd8, 32'd12};
    stall_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
    start_load();
    for (int i = 0; i < 16; i++) send_byte(prog[i]);
    finish_load();
    checks++; if (o_load_words !== 11'd4) begin errors++; $display("FAIL load_words4: got %0d want 4", o_load_words); end
    start_run();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_pc !== exp_pc[i]) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, o_pc, exp_pc[i]); end
      checks++; if (o_pc_next !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL stall_pc_next[%0d]: got %h want %h", i, o_pc_next, exp_pc[i] + 32'd4); end
      if (i < 3) begin
        i_stall = stall_seq[i];
        step();
        i_stall = 1'b0;
      end
    end
    checks++; if (o_instr !== NOP) begin errors++; $display("FAIL stall_halt_nop: got %h want %h", o_instr, NOP); end
  endtask

  task automatic test_redirect();
    i_redirect = 1'b1; i_redirect_pc = 32'h20; i_stall = 1'b1;
    step();
    i_redirect = 1'b0; i_stall = 1'b0;
    checks++; if (o_pc !== 32'h20) begin errors++; $display("FAIL redir_stall_pc: got %h want 20", o_pc); end
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL redir_no_halt: got %0d want 2", o_state); end
    checks++; if (o_pc_next !== 32'h24) begin errors++; $display("FAIL redir_pc_next: got %h want 24", o_pc_next); end
    i_en = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0;
    step();
    checks++; if (o_pc !== 32'h20) begin errors++; $display("FAIL en_low_hold: got %h want 20", o_pc); end
    i_en = 1'b1;
    step();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL redir_pc0: got %h want 0", o_pc); end
    checks++; if (o_instr !== 32'h0000_0093) begin errors++; $display("FAIL redir_instr0: got %h want 00000093", o_instr); end
    i_redirect_pc = 32'd12;
    step();
    checks++; if (o_pc !== 32'd12) begin errors++; $display("FAIL redir_pc12: got %h want c", o_pc); end
    i_redirect_pc = 32'd4; i_load_start = 1'b1; i_run = 1'b1;
    step();
    i_redirect = 1'b0; i_load_start = 1'b0; i_run = 1'b0;
    checks++; if (o_pc !== 32'd4) begin errors++; $display("FAIL redir_over_halt_pc: got %h want 4", o_pc); end
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL run_ignores_load: got %0d want 2", o_state); end
    checks++; if (o_instr !== 32'h0000_0113) begin errors++; $display("FAIL redir_instr4: got %h want 00000113", o_instr); end
    step();
    step();
    step();
    checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL redir_then_halt: got %b want 1", o_halt); end
    checks++; if (o_pc !== 32'd12) begin errors++; $display("FAIL redir_then_halt_pc: got %h want c", o_pc); end
  endtask

  task automatic test_partial_load();
    logic [7:0] prog [0:5];
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    start_load();
    for (int i = 0; i < 6; i++) send_byte(prog[i]);
    finish_load();
    checks++; if (o_load_words !== 11'd1) begin errors++; $display("FAIL partial_words: got %0d want 1", o_load_words); end
    start_run();
    checks++; if (o_instr !== 32'hDDCC_BBAA) begin errors++; $display("FAIL partial_word0: got %h want ddccbbaa", o_instr); end
    step();
    checks++; if (o_instr !== 32'h0000_0113) begin errors++; $display("FAIL partial_word1_kept: got %h want 00000113", o_instr); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] prog [0:3];
    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_mid_run_state: got %0d want 0", o_state); end
    i_load_start = 1'b1; i_run = 1'b1;
    step();
    i_load_start = 1'b0; i_run = 1'b0;
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL load_beats_run: got %0d want 1", o_state); end
    send_byte(8'h55);
    send_byte(8'h66);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_mid_load_state: got %0d want 0", o_state); end
    checks++; if (o_load_words !== 11'd0) begin errors++; $display("FAIL rst_mid_load_words: got %0d want 0", o_load_words); end
    start_load();
    for (int i = 0; i < 4; i++) send_byte(prog[i]);
    finish_load();
    checks++; if (o_load_words !== 11'd1) begin errors++; $display("FAIL reload_words: got %0d want 1", o_load_words); end
    start_run();
    checks++; if (o_instr !== 32'h0403_0201) begin errors++; $display("FAIL reload_word0: got %h want 04030201", o_instr); end
    step();
    checks++; if (o_instr !== 32'h0000_0113) begin errors++; $display("FAIL reload_word1_kept: got %h want 00000113", o_instr); end
  endtask

  initial begin
    test_reset();
    test_load_and_halt();
    test_stall();
    test_redirect();
    test_partial_load();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
